// File: rtl/aes_pkg.sv
// Shared AES inverse-cipher definitions: FSM encoding, S-box tables and the
// byte-level round transforms used by the decryption core and key schedule.
package aes_pkg;

    localparam int NB = 4;

    typedef enum logic [2:0] {IDLE, INIT, ROUND, FINAL, DONE} aes_fsm_e;

    // Row 0 holds entries 0x00..0x0f, so entry x sits at packed index 255-x (~x).
    localparam logic [255:0][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [255:0][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] c);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return (c[0] ? b : 8'h00) ^ (c[1] ? x2 : 8'h00) ^ (c[2] ? x4 : 8'h00) ^ (c[3] ? x8 : 8'h00);
    endfunction

    function automatic logic [7:0] rcon(input int n);
        logic [7:0] r;
        r = 8'h01;
        for (int j = 1; j < 15; j++)
            if (j < n) r = xtime(r);
        return r;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[~w[31:24]], SBOX[~w[23:16]], SBOX[~w[15:8]], SBOX[~w[7:0]]};
    endfunction

    // Byte k of the block is bits [127-8k -: 8]; byte k is row k%4, column k/4.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < NB; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+4)%4)) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int k = 0; k < 16; k++)
            o[127-8*k -: 8] = INV_SBOX[~s[127-8*k -: 8]];
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < NB; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9);
            o[119-32*c -: 8] = gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd);
            o[111-32*c -: 8] = gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb);
            o[103-32*c -: 8] = gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he);
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round; last=1 drops InvMixColumns for the
// final round.
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] state,
    input  logic [127:0] rk,
    input  logic         last,
    output logic [127:0] result
);

    logic [127:0] keyed;

    assign keyed  = inv_sub_bytes(inv_shift_rows(state)) ^ rk;
    assign result = last ? keyed : inv_mix_columns(keyed);

endmodule

// File: rtl/keyExpansion.sv
// Combinational AES key schedule: expands a 32*Nk-bit cipher key into Nr+1
// round keys, round key r placed at fullKey[128*r +: 128].
module keyExpansion
    import aes_pkg::*;
#(
    parameter int Nk = 4,
    parameter int Nr = 10
) (
    input  logic [32*Nk-1:0]      key,
    output logic [128*(Nr+1)-1:0] fullKey
);

    localparam int NW = NB * (Nr + 1);

    logic [31:0] w [NW];
    logic [31:0] tmp;

    always_comb begin
        tmp = '0;
        for (int i = 0; i < NW; i++) begin
            if (i < Nk) begin
                w[i] = key[32*(Nk-1-i) +: 32];
            end else begin
                tmp = w[i-1];
                if (i % Nk == 0)
                    tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {rcon(i / Nk), 24'h000000};
                else if (Nk > 6 && i % Nk == 4)
                    tmp = sub_word(tmp);
                w[i] = w[i-Nk] ^ tmp;
            end
        end
    end

    always_comb begin
        fullKey = '0;
        for (int r = 0; r <= Nr; r++)
            fullKey[128*r +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    end

endmodule

// File: rtl/aes_decrypt_core.sv
// Iterative AES inverse cipher, one round per clock, valid/ready on both sides.
// Optional AES_DEC_ABORT_EN adds an abort input that cancels a block in flight.
module aes_decrypt_core
    import aes_pkg::*;
#(
    parameter int N  = 128,
    parameter int Nr = 10,
    parameter int Nk = 4
) (
    input  logic             clk,
    input  logic             reset,
`ifdef AES_DEC_ABORT_EN
    input  logic             abort,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     cipher_in,
    input  logic [32*Nk-1:0] key,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     plain_out
);

    aes_fsm_e                 fsm_q, fsm_d;
    logic [3:0]               round_q;
    logic [3:0]               rk_idx;
    logic [N-1:0]             state_q;
    logic [32*Nk-1:0]         key_q;
    logic [128*(Nr+1)-1:0]    full_key;
    logic [127:0]             rk;
    logic [127:0]             round_out;
    logic                     abort_hit;

`ifdef AES_DEC_ABORT_EN
    assign abort_hit = abort && (fsm_q != IDLE);
`else
    assign abort_hit = 1'b0;
`endif

    keyExpansion #(.Nk(Nk), .Nr(Nr)) u_key_exp (
        .key     (key_q),
        .fullKey (full_key)
    );

    // INIT whitens with the last round key; later rounds walk round_q down to 0.
    assign rk_idx = (fsm_q == INIT) ? 4'(Nr) : round_q;
    assign rk     = full_key[128*rk_idx +: 128];

    aes_inv_round u_round (
        .state  (state_q),
        .rk     (rk),
        .last   (fsm_q == FINAL),
        .result (round_out)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) fsm_q <= IDLE;
        else        fsm_q <= fsm_d;
    end

    always_comb begin
        fsm_d = fsm_q;
        if (abort_hit) begin
            fsm_d = IDLE;
        end else begin
            case (fsm_q)
                IDLE:    if (in_valid) fsm_d = INIT;
                INIT:    fsm_d = ROUND;
                ROUND:   if (round_q == 4'd1) fsm_d = FINAL;
                FINAL:   fsm_d = DONE;
                DONE:    if (out_ready) fsm_d = IDLE;
                default: fsm_d = IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready  = (fsm_q == IDLE);
        out_valid = (fsm_q == DONE);
    end

    assign plain_out = state_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= '0;
            key_q   <= '0;
            round_q <= '0;
        end else if (abort_hit) begin
            state_q <= '0;
        end else begin
            case (fsm_q)
                IDLE: if (in_valid) begin
                    state_q <= cipher_in;
                    key_q   <= key;
                end
                INIT: begin
                    state_q <= state_q ^ rk;
                    round_q <= 4'(Nr - 1);
                end
                ROUND: begin
                    state_q <= round_out;
                    round_q <= round_q - 4'd1;
                end
                FINAL:   state_q <= round_out;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_decrypt_core.sv
// Directed bench for aes_decrypt_core (AES-128): known-answer vectors,
// busy-input rejection, backpressure, mid-block reset and optional abort.
module tb_aes_decrypt_core;

    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam logic [127:0] KEY_Z = 128'h0;
    localparam logic [127:0] PT_Z  = 128'h0;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid, in_ready, out_valid, out_ready;
    logic [127:0] cipher_in, key, plain_out;
`ifdef AES_DEC_ABORT_EN
    logic         abort;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int accept_cyc = 0;
    logic [127:0] exp_q[$];

    aes_decrypt_core dut (
        .clk       (clk),
        .reset     (reset),
`ifdef AES_DEC_ABORT_EN
        .abort     (abort),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .cipher_in (cipher_in),
        .key       (key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .plain_out (plain_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [127:0] ct, input logic [127:0] k,
                        input logic [127:0] pt, input bit push);
        check("accept_ready", {127'd0, in_ready}, 128'd1);
        in_valid  = 1'b1;
        cipher_in = ct;
        key       = k;
        tick();
        accept_cyc = cyc;
        in_valid   = 1'b0;
        if (push) exp_q.push_back(pt);
        check("busy_ready", {127'd0, in_ready}, 128'd0);
    endtask

    task automatic wait_result(input string tag, input int lat);
        int n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        if (!out_valid) begin
            check({tag, "_timeout"}, 128'd0, 128'd1);
        end else begin
            check({tag, "_latency"}, 128'(cyc - accept_cyc), 128'(lat));
            check({tag, "_data"}, plain_out, exp_q.pop_front());
        end
    endtask

    task automatic expect_silence(input string tag, input int n);
        logic seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick();
            seen |= out_valid;
        end
        check(tag, {127'd0, seen}, 128'd0);
    endtask

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cipher_in = '0;
        key       = '0;
`ifdef AES_DEC_ABORT_EN
        abort     = 1'b0;
`endif
        repeat (3) tick();
        check("rst_out_valid", {127'd0, out_valid}, 128'd0);
        check("rst_plain", plain_out, 128'd0);
        check("rst_in_ready", {127'd0, in_ready}, 128'd1);
        reset = 1'b1;
        tick();
        check("post_rst_in_ready", {127'd0, in_ready}, 128'd1);

        // FIPS-197 App. B, out_valid exactly 11 edges after accept
        send(CT_B, KEY_B, PT_B, 1'b1);
        wait_result("appb", 11);
        tick();
        check("appb_back_idle", {127'd0, in_ready}, 128'd1);
        check("appb_valid_drop", {127'd0, out_valid}, 128'd0);

        // C.1 with a different block held on the input while busy
        send(CT_C, KEY_C, PT_C, 1'b1);
        in_valid  = 1'b1;
        cipher_in = CT_Z;
        key       = KEY_Z;
        wait_result("c1", 11);
        tick();
        check("busy_no_accept_in_done", {127'd0, in_ready}, 128'd1);
        tick();
        accept_cyc = cyc;
        in_valid   = 1'b0;
        exp_q.push_back(PT_Z);
        check("busy_second_accept", {127'd0, in_ready}, 128'd0);
        wait_result("zero_key", 11);
        tick();

        // Backpressure: result must sit still while the sink stalls
        out_ready = 1'b0;
        send(CT_B, KEY_B, PT_B, 1'b1);
        wait_result("bp", 11);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("bp_hold_data", plain_out, PT_B);
            check("bp_hold_valid", {127'd0, out_valid}, 128'd1);
            check("bp_hold_ready", {127'd0, in_ready}, 128'd0);
        end
        out_ready = 1'b1;
        tick();
        check("bp_release_ready", {127'd0, in_ready}, 128'd1);
        check("bp_release_valid", {127'd0, out_valid}, 128'd0);

        // Asynchronous reset at round 5 discards the block
        send(CT_C, KEY_C, PT_C, 1'b0);
        repeat (5) tick();
        reset = 1'b0;
        #1;
        check("midrst_out_valid", {127'd0, out_valid}, 128'd0);
        check("midrst_plain", plain_out, 128'd0);
        check("midrst_in_ready", {127'd0, in_ready}, 128'd1);
        tick();
        reset = 1'b1;
        tick();
        check("midrst_release_ready", {127'd0, in_ready}, 128'd1);
        expect_silence("midrst_no_output", 15);
        send(CT_B, KEY_B, PT_B, 1'b1);
        wait_result("after_rst", 11);
        tick();

`ifdef AES_DEC_ABORT_EN
        send(CT_C, KEY_C, PT_C, 1'b0);
        repeat (4) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_out_valid", {127'd0, out_valid}, 128'd0);
        check("abort_in_ready", {127'd0, in_ready}, 128'd1);
        check("abort_plain", plain_out, 128'd0);
        expect_silence("abort_no_output", 15);
        send(CT_C, KEY_C, PT_C, 1'b1);
        wait_result("after_abort", 11);
        tick();
`endif

        check("scoreboard_empty", 128'(exp_q.size()), 128'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
